// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard beside the ID stage: per-register latency countdowns,
// long-unit occupancy tracking, branch flushes and a saturating stall counter.
module hazard_scoreboard #(
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_LAT   = 1,
    parameter int LONG_LAT   = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_is_long,
    input  logic                  ex_branch_taken,
    output logic                  pc_enable,
    output logic                  if_id_write_enable,
    output logic                  control_enable,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic [CNT_W-1:0]      stall_count
);

    localparam int NUM_REGS = 2 ** REG_ADDR_W;
    localparam int MAX_LAT  = (LOAD_LAT > LONG_LAT) ? LOAD_LAT : LONG_LAT;
    localparam int LAT_W    = $clog2(MAX_LAT + 1);
    localparam int LB_W     = $clog2(LONG_LAT + 1);
    localparam logic [LAT_W-1:0] LOAD_L = LAT_W'(LOAD_LAT);
    localparam logic [LAT_W-1:0] LONG_L = LAT_W'(LONG_LAT);
    localparam logic [LB_W-1:0]  BUSY_L = LB_W'(LONG_LAT);

    logic [LAT_W-1:0] r_cnt [NUM_REGS];
    logic [LB_W-1:0]  r_long_busy;
    logic [CNT_W-1:0] r_stall_count;

    logic             w_raw_rs1;
    logic             w_raw_rs2;
    logic             w_raw;
    logic             w_struct;
    logic             w_stall;
    logic             w_issue;
    logic             w_wr_en;
    logic [LAT_W-1:0] w_lat;

    function automatic logic [LAT_W-1:0] dec_cnt(input logic [LAT_W-1:0] v);
        return (v != '0) ? v - LAT_W'(1) : '0;
    endfunction

    always_comb begin
        w_raw_rs1 = id_uses_rs1 && (id_rs1 != '0) && (r_cnt[id_rs1] != '0);
        w_raw_rs2 = id_uses_rs2 && (id_rs2 != '0) && (r_cnt[id_rs2] != '0);
        w_raw     = id_valid && (w_raw_rs1 || w_raw_rs2);
        w_struct  = id_valid && id_is_long && (r_long_busy != '0);
        // a taken branch squashes ID, so it never stalls there
        w_stall   = (w_raw || w_struct) && !ex_branch_taken;
        w_issue   = id_valid && !w_stall && !ex_branch_taken;
        w_wr_en   = w_issue && id_reg_write && (id_rd != '0);
    end

    always_comb begin
        w_lat = '0;
        if (id_mem_read)
            w_lat = LOAD_L;
        else if (id_is_long)
            w_lat = LONG_L;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++)
                r_cnt[i] <= '0;
            r_long_busy   <= '0;
            r_stall_count <= '0;
        end else begin
            r_cnt[0] <= '0;
            // max() keeps the later completion on write-after-write
            for (int i = 1; i < NUM_REGS; i++) begin
                if (w_wr_en && (id_rd == REG_ADDR_W'(i)))
                    r_cnt[i] <= (dec_cnt(r_cnt[i]) > w_lat) ? dec_cnt(r_cnt[i]) : w_lat;
                else
                    r_cnt[i] <= dec_cnt(r_cnt[i]);
            end

            if (w_issue && id_is_long)
                r_long_busy <= BUSY_L;
            else if (r_long_busy != '0)
                r_long_busy <= r_long_busy - LB_W'(1);

            if (w_stall && (r_stall_count != '1))
                r_stall_count <= r_stall_count + CNT_W'(1);
        end
    end

    always_comb begin
        pc_enable          = !w_stall;
        if_id_write_enable = !w_stall;
        control_enable     = !w_stall;
        if_id_flush        = ex_branch_taken;
        id_ex_flush        = ex_branch_taken;
        stall_count        = r_stall_count;
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: dut_a uses LOAD_LAT=1/CNT_W=16, dut_b uses LOAD_LAT=3/CNT_W=4;
// both share the same ID-stage stimulus.
module tb_hazard_scoreboard;

    logic       clk;
    logic       reset_n;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic [4:0] id_rd;
    logic       id_reg_write;
    logic       id_mem_read;
    logic       id_is_long;
    logic       ex_branch_taken;

    logic        a_pc, a_ifid, a_ctrl, a_iff, a_ief;
    logic [15:0] a_cnt;
    logic        b_pc, b_ifid, b_ctrl, b_iff, b_ief;
    logic [3:0]  b_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int n_stall;

    hazard_scoreboard #(.REG_ADDR_W(5), .LOAD_LAT(1), .LONG_LAT(4), .CNT_W(16)) dut_a (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_is_long(id_is_long), .ex_branch_taken(ex_branch_taken),
        .pc_enable(a_pc), .if_id_write_enable(a_ifid), .control_enable(a_ctrl),
        .if_id_flush(a_iff), .id_ex_flush(a_ief), .stall_count(a_cnt)
    );

    hazard_scoreboard #(.REG_ADDR_W(5), .LOAD_LAT(3), .LONG_LAT(4), .CNT_W(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_is_long(id_is_long), .ex_branch_taken(ex_branch_taken),
        .pc_enable(b_pc), .if_id_write_enable(b_ifid), .control_enable(b_ctrl),
        .if_id_flush(b_iff), .id_ex_flush(b_ief), .stall_count(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic wr, input logic mem, input logic lng, input logic br);
        id_valid = v;  id_rs1 = rs1; id_uses_rs1 = u1; id_rs2 = rs2; id_uses_rs2 = u2;
        id_rd = rd; id_reg_write = wr; id_mem_read = mem; id_is_long = lng;
        ex_branch_taken = br;
    endtask

    task automatic idle();
        drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic apply_reset();
        idle();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    // counts consecutive stalled cycles of the current ID instruction; returns in its issue cycle
    task automatic count_stalls(input bit use_b, output int n);
        n = 0;
        for (int k = 0; k < 50; k++) begin
            #1;
            if ((use_b ? b_pc : a_pc) == 1'b1)
                return;
            n++;
            step();
        end
        chk("stall_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        step();
        apply_reset();
        #1;
        chk("rst_pc_a", a_pc, 1);
        chk("rst_ctrl_b", b_ctrl, 1);
        chk("rst_flush_a", a_iff, 0);
        chk("rst_cnt_a", a_cnt, 0);
        chk("rst_cnt_b", b_cnt, 0);

        // classic load-use on LOAD_LAT=1
        drv(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
        #1 chk("t1_load_pc", a_pc, 1);
        step();
        drv(1, 5, 1, 0, 0, 6, 1, 0, 0, 0);
        #1;
        chk("t1_stall_pc", a_pc, 0);
        chk("t1_stall_ifid", a_ifid, 0);
        chk("t1_stall_ctrl", a_ctrl, 0);
        chk("t1_cnt_before", a_cnt, 0);
        step();
        chk("t1_issue_pc", a_pc, 1);
        chk("t1_cnt_after", a_cnt, 1);
        step();
        idle();

        // LOAD_LAT=3: immediate dependent, then one independent in between
        apply_reset();
        drv(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
        step();
        drv(1, 7, 1, 0, 0, 8, 1, 0, 0, 0);
        count_stalls(1, n_stall);
        chk("t2_imm_stalls", n_stall, 3);
        step();
        idle();
        chk("t2_cnt_imm", b_cnt, 3);
        drv(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
        step();
        drv(1, 1, 1, 0, 0, 9, 1, 0, 0, 0);
        #1 chk("t2_indep_pc", b_pc, 1);
        step();
        drv(1, 7, 1, 0, 0, 8, 1, 0, 0, 0);
        count_stalls(1, n_stall);
        chk("t2_gap_stalls", n_stall, 2);
        step();
        idle();
        chk("t2_cnt_gap", b_cnt, 5);

        // load to x0 never scoreboards
        drv(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        step();
        drv(1, 0, 1, 0, 1, 10, 1, 0, 0, 0);
        #1;
        chk("t3_x0_pc_b", b_pc, 1);
        chk("t3_x0_pc_a", a_pc, 1);
        step();
        idle();
        chk("t3_x0_cnt_b", b_cnt, 5);

        // long unit: structural hazard, then RAW on long result
        apply_reset();
        drv(1, 1, 1, 2, 1, 3, 1, 0, 1, 0);
        step();
        idle();
        step();
        drv(1, 5, 1, 6, 1, 4, 1, 0, 1, 0);
        count_stalls(1, n_stall);
        chk("t4_struct_stalls", n_stall, 3);
        step();
        idle();
        chk("t4_struct_cnt_a", a_cnt, 3);
        apply_reset();
        drv(1, 1, 1, 2, 1, 3, 1, 0, 1, 0);
        step();
        idle();
        step();
        step();
        drv(1, 3, 1, 0, 0, 11, 1, 0, 0, 0);
        count_stalls(0, n_stall);
        chk("t4_raw_stalls", n_stall, 2);
        step();
        idle();

        // taken branch beats a load-use stall; flushed load leaves no trace
        apply_reset();
        drv(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
        step();
        drv(1, 5, 1, 0, 0, 6, 1, 0, 0, 1);
        #1;
        chk("t5_iff", a_iff, 1);
        chk("t5_ief", a_ief, 1);
        chk("t5_pc", a_pc, 1);
        chk("t5_ctrl", a_ctrl, 1);
        step();
        chk("t5_cnt", a_cnt, 0);
        drv(1, 0, 0, 0, 0, 9, 1, 1, 0, 1);
        step();
        drv(1, 9, 1, 0, 0, 12, 1, 0, 0, 0);
        #1;
        chk("t5_x9_pc_a", a_pc, 1);
        chk("t5_x9_pc_b", b_pc, 1);
        step();
        idle();
        chk("t5_x9_cnt_b", b_cnt, 0);

        // saturation: self-dependent load chain on x7, then async reset mid-stall
        apply_reset();
        drv(1, 7, 1, 0, 0, 7, 1, 1, 0, 0);
        repeat (8) step();
        chk("t6_cnt_b_8", b_cnt, 6);
        chk("t6_cnt_a_8", a_cnt, 4);
        repeat (20) step();
        chk("t6_sat_b", b_cnt, 15);
        chk("t6_cnt_a_28", a_cnt, 14);
        step();
        chk("t6_stall_b", b_pc, 0);
        chk("t6_hold_b", b_cnt, 15);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_pc_b", b_pc, 1);
        chk("t6_rst_ctrl_b", b_ctrl, 1);
        chk("t6_rst_ifid_a", a_ifid, 1);
        chk("t6_rst_cnt_b", b_cnt, 0);
        chk("t6_rst_cnt_a", a_cnt, 0);
        chk("t6_rst_flush_b", b_ief, 0);
        step();
        reset_n = 1'b1;
        idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
